mem_load_resp: RTL and testbench

//  Load-return side of the data memory interface; counterpart to the MEM-stage store path (wen/wdata/ADE).

---
 rtl/mem_load_resp_pkg.sv | 14 +
 rtl/mem_load_resp_load_align.sv | 49 ++++
 rtl/mem_load_resp.sv | 117 +++++++++++
 tb/tb_mem_load_resp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_resp_pkg.sv
// Shared load-return definitions: ALUOP load encodings used by the MEM/WB datapath.
package mem_load_resp_pkg;

    localparam int ALUOP_BITS = 8;

    localparam logic [ALUOP_BITS-1:0] ALUOP_LB  = 8'h20;
    localparam logic [ALUOP_BITS-1:0] ALUOP_LBU = 8'h21;
    localparam logic [ALUOP_BITS-1:0] ALUOP_LH  = 8'h22;
    localparam logic [ALUOP_BITS-1:0] ALUOP_LHU = 8'h23;
    localparam logic [ALUOP_BITS-1:0] ALUOP_LW  = 8'h24;
    localparam logic [ALUOP_BITS-1:0] ALUOP_LWL = 8'h25;
    localparam logic [ALUOP_BITS-1:0] ALUOP_LWR = 8'h26;

endpackage

// File: rtl/mem_load_resp_load_align.sv
// Combinational load aligner: byte/half select with extension, and LWL/LWR merge with old rt.
module load_align
    import mem_load_resp_pkg::*;
#(
    parameter int ALUOP_W = 8
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         b,
    input  logic [31:0]        m,
    input  logic [31:0]        r,
    output logic [31:0]        word
);

    logic [31:0]        shifted;
    logic signed [7:0]  sel_byte;
    logic signed [15:0] sel_half;

    always_comb begin
        shifted  = m >> {b, 3'b000};
        sel_byte = $signed(shifted[7:0]);
        sel_half = b[1] ? $signed(m[31:16]) : $signed(m[15:0]);
        word     = m;
        case (aluop)
            ALUOP_LB:  word = {{24{sel_byte[7]}}, sel_byte};
            ALUOP_LBU: word = {24'd0, sel_byte};
            ALUOP_LH:  word = {{16{sel_half[15]}}, sel_half};
            ALUOP_LHU: word = {16'd0, sel_half};
            ALUOP_LW:  word = m;
            ALUOP_LWL: begin
                case (b)
                    2'd0:    word = {m[7:0],  r[23:0]};
                    2'd1:    word = {m[15:0], r[15:0]};
                    2'd2:    word = {m[23:0], r[7:0]};
                    default: word = m;
                endcase
            end
            ALUOP_LWR: begin
                case (b)
                    2'd0:    word = m;
                    2'd1:    word = {r[31:24], m[31:8]};
                    2'd2:    word = {r[31:16], m[31:16]};
                    default: word = {r[31:8],  m[31:24]};
                endcase
            end
            default:   word = m;
        endcase
    end

endmodule

// File: rtl/mem_load_resp.sv
// Load-return tracker: one outstanding load, stale-response discard after flush, result held for WB.
module mem_load_resp
    import mem_load_resp_pkg::*;
#(
    parameter int DISCARD_MAX = 3,
    parameter int ALUOP_W     = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        rt_data_i,
    input  logic               exception_i,
    input  logic               flush_i,
    input  logic               data_addr_ok_i,
    input  logic               data_data_ok_i,
    input  logic [31:0]        data_rdata_i,
    input  logic               wb_allowin_i,
    output logic [31:0]        load_data_o,
    output logic               load_valid_o,
    output logic               stall_o,
    output logic               discard_ovf_o
);

    localparam int CNT_W = $clog2(DISCARD_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   discard_cnt;
    logic [ALUOP_W-1:0] req_aluop_p1;
    logic [1:0]         req_b_p1;
    logic [31:0]        req_rt_p1;
    logic [31:0]        aligned;
    logic               accept, stale, own_ok, cnt_inc, cnt_dec;
    logic               unused_addr;

    assign unused_addr = ^addr_i[31:2];

    // Stale responses always drain ahead of the current load's response.
    assign stale   = data_data_ok_i & (discard_cnt != '0);
    assign own_ok  = data_data_ok_i & (discard_cnt == '0) & (state == S_WAIT);
    assign cnt_inc = flush_i & (state == S_WAIT) & ~own_ok;
    assign cnt_dec = stale;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall_o   = 1'b0;
        case (state)
            S_IDLE: begin
                accept  = req_valid_i & data_addr_ok_i & ~exception_i & ~flush_i;
                stall_o = req_valid_i & ~data_addr_ok_i;
                if (accept) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (flush_i)     state_nxt = S_IDLE;
                else if (own_ok) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                stall_o = ~wb_allowin_i;
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (wb_allowin_i) begin
                    accept    = req_valid_i & data_addr_ok_i & ~exception_i;
                    state_nxt = accept ? S_WAIT : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush_i) stall_o = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            discard_cnt   <= '0;
            discard_ovf_o <= 1'b0;
            load_data_o   <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_dec && !cnt_inc) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end else if (cnt_inc && !cnt_dec) begin
                if (discard_cnt == CNT_W'(DISCARD_MAX)) discard_ovf_o <= 1'b1;
                else                                    discard_cnt   <= discard_cnt + CNT_W'(1);
            end
            if (own_ok && !flush_i) load_data_o <= aligned;
        end
    end

    // Request capture (p1): fields consumed when the response returns.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_aluop_p1 <= aluop_i;
            req_b_p1     <= addr_i[1:0];
            req_rt_p1    <= rt_data_i;
        end
    end

    assign load_valid_o = (state == S_HOLD);

    load_align #(.ALUOP_W(ALUOP_W)) u_load_align (
        .aluop (req_aluop_p1),
        .b     (req_b_p1),
        .m     (data_rdata_i),
        .r     (req_rt_p1),
        .word  (aligned)
    );

endmodule

// File: tb/tb_mem_load_resp.sv
// Directed bench for mem_load_resp: alignment, hold/stall, flush discard, reset and overflow.
module tb_mem_load_resp;
    import mem_load_resp_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid_i;
    logic [7:0]  aluop_i;
    logic [31:0] addr_i;
    logic [31:0] rt_data_i;
    logic        exception_i;
    logic        flush_i;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        wb_allowin_i;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        stall_o;
    logic        discard_ovf_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_load_resp #(.DISCARD_MAX(3), .ALUOP_W(8)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req_valid_i    (req_valid_i),
        .aluop_i        (aluop_i),
        .addr_i         (addr_i),
        .rt_data_i      (rt_data_i),
        .exception_i    (exception_i),
        .flush_i        (flush_i),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .wb_allowin_i   (wb_allowin_i),
        .load_data_o    (load_data_o),
        .load_valid_o   (load_valid_o),
        .stall_o        (stall_o),
        .discard_ovf_o  (discard_ovf_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_valid_i    = 1'b0;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        exception_i    = 1'b0;
        flush_i        = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt);
        aluop_i        = op;
        addr_i         = addr;
        rt_data_i      = rt;
        req_valid_i    = 1'b1;
        data_addr_ok_i = 1'b1;
        step();
        req_valid_i    = 1'b0;
        data_addr_ok_i = 1'b0;
        #1;
    endtask

    task automatic respond(input logic [31:0] m);
        data_data_ok_i = 1'b1;
        data_rdata_i   = m;
        step();
        data_data_ok_i = 1'b0;
        #1;
    endtask

    task automatic do_load(input string tag, input logic [7:0] op, input logic [1:0] b,
                           input logic [31:0] rt, input logic [31:0] m, input logic [31:0] exp);
        issue(op, {30'h0, b}, rt);
        chk({tag, "_wait_stall"}, 32'(stall_o), 32'd1);
        respond(m);
        chk({tag, "_valid"}, 32'(load_valid_o), 32'd1);
        chk({tag, "_data"}, load_data_o, exp);
        step();
        chk({tag, "_done"}, 32'(load_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        clear_in();
        wb_allowin_i = 1'b1;
        aluop_i      = 8'h0;
        addr_i       = 32'h0;
        rt_data_i    = 32'h0;
        data_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(load_valid_o), 32'd0);
        chk("rst_data", load_data_o, 32'h0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ovf", 32'(discard_ovf_o), 32'd0);
        resetn = 1'b1;
        step();

        // Request without address handshake stalls; exception blocks tracking.
        req_valid_i = 1'b1;
        #1;
        chk("idle_noaddr_stall", 32'(stall_o), 32'd1);
        data_addr_ok_i = 1'b1;
        exception_i    = 1'b1;
        step();
        clear_in();
        #1;
        chk("exc_not_tracked", 32'(stall_o), 32'd0);

        do_load("lb3",  ALUOP_LB,  2'd3, 32'h0,        32'h80FF1234, 32'hFFFFFF80);
        do_load("lbu3", ALUOP_LBU, 2'd3, 32'h0,        32'h80FF1234, 32'h00000080);
        do_load("lh2",  ALUOP_LH,  2'd2, 32'h0,        32'h80FF1234, 32'hFFFF80FF);
        do_load("lhu0", ALUOP_LHU, 2'd0, 32'h0,        32'h80FF1234, 32'h00001234);
        do_load("lwl1", ALUOP_LWL, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD);
        do_load("lwr2", ALUOP_LWR, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122);
        do_load("lwr3", ALUOP_LWR, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11);
        do_load("lw0",  ALUOP_LW,  2'd0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D);

        // WB back-pressure for 3 cycles.
        wb_allowin_i = 1'b0;
        issue(ALUOP_LW, 32'h0, 32'h0);
        respond(32'hCAFEBABE);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wb_allowin_i = 1'b1;
            #1;
            chk($sformatf("hold%0d_valid", i), 32'(load_valid_o), 32'd1);
            chk($sformatf("hold%0d_data", i), load_data_o, 32'hCAFEBABE);
            chk($sformatf("hold%0d_stall", i), 32'(stall_o), (i < 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("hold_release", 32'(load_valid_o), 32'd0);

        // Flush in WAIT leaves a stale response to discard.
        issue(ALUOP_LW, 32'h0, 32'h0);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", 32'(stall_o), 32'd0);
        step();
        flush_i = 1'b0;
        issue(ALUOP_LW, 32'h0, 32'h0);
        respond(32'h0000DEAD);
        chk("stale_dropped", 32'(load_valid_o), 32'd0);
        chk("stale_still_wait", 32'(stall_o), 32'd1);
        respond(32'h12345678);
        chk("post_stale_valid", 32'(load_valid_o), 32'd1);
        chk("post_stale_data", load_data_o, 32'h12345678);
        step();

        // Flush coinciding with the own response: dropped, counter untouched.
        issue(ALUOP_LW, 32'h0, 32'h0);
        flush_i        = 1'b1;
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'h00000BAD;
        step();
        clear_in();
        #1;
        chk("flushok_valid", 32'(load_valid_o), 32'd0);
        chk("flushok_stall", 32'(stall_o), 32'd0);
        do_load("cnt_zero", ALUOP_LW, 2'd0, 32'h0, 32'h55AA55AA, 32'h55AA55AA);

        // Back-to-back accept on HOLD exit.
        issue(ALUOP_LW, 32'h0, 32'h0);
        respond(32'h01020304);
        aluop_i        = ALUOP_LB;
        addr_i         = 32'h3;
        req_valid_i    = 1'b1;
        data_addr_ok_i = 1'b1;
        #1;
        chk("b2b_first", load_data_o, 32'h01020304);
        step();
        clear_in();
        #1;
        chk("b2b_gap_valid", 32'(load_valid_o), 32'd0);
        chk("b2b_wait_stall", 32'(stall_o), 32'd1);
        respond(32'h80FF1234);
        chk("b2b_second", load_data_o, 32'hFFFFFF80);
        step();

        // Reset during WAIT.
        issue(ALUOP_LW, 32'h0, 32'h0);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 32'(load_valid_o), 32'd0);
        chk("midrst_data", load_data_o, 32'h0);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'h77777777;
        step();
        resetn = 1'b1;
        step();
        data_data_ok_i = 1'b0;
        #1;
        chk("postrst_valid", 32'(load_valid_o), 32'd0);
        chk("postrst_data", load_data_o, 32'h0);

        // Four flushes without responses saturate the discard counter.
        for (int i = 0; i < 4; i++) begin
            issue(ALUOP_LW, 32'h0, 32'h0);
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            #1;
            if (i == 2) chk("ovf_before", 32'(discard_ovf_o), 32'd0);
            if (i == 3) chk("ovf_after", 32'(discard_ovf_o), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
